// File: rtl/fp_result_buf_pkg.sv
// Shared IEEE-754 result-class flags and exception-bit definitions.
// Any block that carries adder results imports this package.
package fp_result_buf_pkg;

    // Result class one-hot vector width and bit positions
    localparam int NTYPES    = 6;
    localparam int SNAN      = 0;
    localparam int QNAN      = 1;
    localparam int INFINITY  = 2;
    localparam int ZERO      = 3;
    localparam int NORMAL    = 4;
    localparam int SUBNORMAL = 5;

    // IEEE-754 exception vector width and bit positions
    localparam int NEXCEPTIONS = 5;
    localparam int INVALID     = 0;
    localparam int DIVZERO     = 1;
    localparam int OVERFLOW    = 2;
    localparam int UNDERFLOW   = 3;
    localparam int INEXACT     = 4;

    // Width of one stored FIFO entry: word, class flags, exceptions
    function automatic int entry_width(input int nexp, input int nsig);
        return nexp + nsig + 1 + NTYPES + NEXCEPTIONS;
    endfunction

endpackage

// File: rtl/fp_fifo_mem.sv
// Result FIFO storage: register array, one write port, asynchronous read.
// No reset: contents are only meaningful behind the read pointer and level.
module fp_fifo_mem #(
    parameter int W     = 27,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Write the addressed entry on an accepted push
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Head entry is read combinationally from the registered read pointer
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fp_result_buf.sv
// Adder result buffer: FIFO of {word, class flags, exceptions} with sticky
// IEEE-754 status flags and a registered trap request.
module fp_result_buf
    import fp_result_buf_pkg::*;
#(
    parameter int NEXP  = 5,
    parameter int NSIG  = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NEXP+NSIG:0]         in_s,
    input  logic [NTYPES-1:0]          in_flags,
    input  logic [NEXCEPTIONS-1:0]     in_exc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NEXP+NSIG:0]         out_s,
    output logic [NTYPES-1:0]          out_flags,
    output logic [NEXCEPTIONS-1:0]     out_exc,
    output logic [NEXCEPTIONS-1:0]     status,
    input  logic                       status_clr,
    input  logic [NEXCEPTIONS-1:0]     trap_en,
    output logic                       trap,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int SW = NEXP + NSIG + 1;
    localparam int EW = entry_width(NEXP, NSIG);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic [NEXCEPTIONS-1:0] status_q, status_d;
    logic                   trap_q, trap_d;
    logic                   push, pop;
    logic [EW-1:0]          wr_entry, rd_entry;

    // Handshakes depend only on registered occupancy; reset masks both sides
    assign in_ready  = ~rst & (level_q < LW'(DEPTH));
    assign out_valid = ~rst & (level_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state: pointers wrap naturally at DEPTH (power of two),
    // the sticky clear is applied before OR-ing in the accepted push
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        status_d = (status_clr ? '0 : status_q) | (push ? in_exc : '0);
        trap_d   = |(status_d & trap_en);
    end

    // State registers with synchronous reset; storage is left untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            status_q <= '0;
            trap_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            status_q <= status_d;
            trap_q   <= trap_d;
        end
    end

    assign wr_entry = {in_s, in_flags, in_exc};

    fp_fifo_mem #(
        .W     (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    assign out_s     = rd_entry[EW-1 -: SW];
    assign out_flags = rd_entry[NTYPES+NEXCEPTIONS-1 -: NTYPES];
    assign out_exc   = rd_entry[NEXCEPTIONS-1:0];
    assign status    = status_q;
    assign trap      = trap_q;
    assign level     = level_q;

endmodule

// File: tb/tb_fp_result_buf.sv
// Testbench for fp_result_buf: table vectors, directed corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_fp_result_buf;
    import fp_result_buf_pkg::*;

    localparam int NEXP  = 5;
    localparam int NSIG  = 10;
    localparam int DEPTH = 4;
    localparam int SW    = NEXP + NSIG + 1;
    localparam int LW    = $clog2(DEPTH + 1);

    localparam logic [NEXCEPTIONS-1:0] X_INV = NEXCEPTIONS'(1 << INVALID);
    localparam logic [NEXCEPTIONS-1:0] X_DZ  = NEXCEPTIONS'(1 << DIVZERO);
    localparam logic [NEXCEPTIONS-1:0] X_OVF = NEXCEPTIONS'(1 << OVERFLOW);
    localparam logic [NEXCEPTIONS-1:0] X_INX = NEXCEPTIONS'(1 << INEXACT);
    localparam logic [NTYPES-1:0]      F_NRM = NTYPES'(1 << NORMAL);
    localparam logic [NTYPES-1:0]      F_INF = NTYPES'(1 << INFINITY);

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [SW-1:0]          in_s;
    logic [NTYPES-1:0]      in_flags;
    logic [NEXCEPTIONS-1:0] in_exc;
    logic                   out_valid;
    logic                   out_ready;
    logic [SW-1:0]          out_s;
    logic [NTYPES-1:0]      out_flags;
    logic [NEXCEPTIONS-1:0] out_exc;
    logic [NEXCEPTIONS-1:0] status;
    logic                   status_clr;
    logic [NEXCEPTIONS-1:0] trap_en;
    logic                   trap;
    logic [LW-1:0]          level;

    fp_result_buf #(.NEXP(NEXP), .NSIG(NSIG), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_s       (in_s),
        .in_flags   (in_flags),
        .in_exc     (in_exc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_s      (out_s),
        .out_flags  (out_flags),
        .out_exc    (out_exc),
        .status     (status),
        .status_clr (status_clr),
        .trap_en    (trap_en),
        .trap       (trap),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of entries plus sticky status and trap
    typedef struct {
        logic [SW-1:0]          s;
        logic [NTYPES-1:0]      f;
        logic [NEXCEPTIONS-1:0] e;
    } ent_t;

    ent_t                   mq[$];
    logic [NEXCEPTIONS-1:0] m_status;
    logic                   m_trap;

    int n_tests;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check combinational handshakes,
    // advance the model, take the edge and compare registered state.
    task automatic cyc(input bit r, input bit v, input logic [SW-1:0] s,
                       input logic [NTYPES-1:0] f, input logic [NEXCEPTIONS-1:0] e,
                       input bit ordy, input bit clr, input logic [NEXCEPTIONS-1:0] te);
        bit   exp_rdy, exp_vld, acc, take;
        ent_t ne;
        rst        = r;
        in_valid   = v;
        in_s       = s;
        in_flags   = f;
        in_exc     = e;
        out_ready  = ordy;
        status_clr = clr;
        trap_en    = te;
        #1;
        exp_rdy = !r && (mq.size() < DEPTH);
        exp_vld = !r && (mq.size() > 0);
        chk("in_ready_pre", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid_pre", 32'(out_valid), 32'(exp_vld));
        acc  = v && exp_rdy;
        take = exp_vld && ordy;
        if (r) begin
            mq.delete();
            m_status = '0;
            m_trap   = 1'b0;
        end else begin
            if (take) void'(mq.pop_front());
            if (acc) begin
                ne.s = s;
                ne.f = f;
                ne.e = e;
                mq.push_back(ne);
            end
            m_status = (clr ? '0 : m_status) | (acc ? e : '0);
            m_trap   = |(m_status & te);
        end
        @(posedge clk);
        #1;
        chk("level", 32'(level), 32'(mq.size()));
        chk("out_valid", 32'(out_valid), 32'(!r && mq.size() > 0));
        chk("status", 32'(status), 32'(m_status));
        chk("trap", 32'(trap), 32'(m_trap));
        if (!r && mq.size() > 0) begin
            chk("out_s", 32'(out_s), 32'(mq[0].s));
            chk("out_flags", 32'(out_flags), 32'(mq[0].f));
            chk("out_exc", 32'(out_exc), 32'(mq[0].e));
        end
    endtask

    typedef struct {
        bit                     r;
        bit                     v;
        logic [SW-1:0]          s;
        logic [NTYPES-1:0]      f;
        logic [NEXCEPTIONS-1:0] e;
        bit                     ordy;
        bit                     clr;
        logic [NEXCEPTIONS-1:0] te;
        bit                     ev;
        logic [SW-1:0]          es;
        int                     elev;
        logic [NEXCEPTIONS-1:0] est;
        bit                     etr;
    } vec_t;

    vec_t tbl[9];
    logic [SW-1:0] exp_drain[4];

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        m_status = '0;
        m_trap   = 1'b0;

        //           r  v  s         f      e            ordy clr te     ev es        lev status       trap
        tbl[0] = '{1, 0, 16'h0000, '0,    '0,          0,   0,  '0,    0, 16'h0000, 0, '0,          0};
        tbl[1] = '{0, 1, 16'h3C00, F_NRM, '0,          0,   0,  '0,    1, 16'h3C00, 1, '0,          0};
        tbl[2] = '{0, 1, 16'h7C00, F_INF, X_OVF|X_INX, 0,   0,  X_OVF, 1, 16'h3C00, 2, X_OVF|X_INX, 1};
        tbl[3] = '{0, 0, 16'h0000, '0,    '0,          1,   0,  X_OVF, 1, 16'h7C00, 1, X_OVF|X_INX, 1};
        tbl[4] = '{0, 0, 16'h0000, '0,    '0,          0,   1,  X_OVF, 1, 16'h7C00, 1, '0,          0};
        tbl[5] = '{0, 1, 16'h1234, F_NRM, X_INX,       0,   0,  '0,    1, 16'h7C00, 2, X_INX,       0};
        tbl[6] = '{0, 1, 16'h4000, F_NRM, X_INV,       0,   1,  X_INV, 1, 16'h7C00, 3, X_INV,       1};
        tbl[7] = '{0, 0, 16'h5555, F_NRM, X_DZ,        0,   0,  '0,    1, 16'h7C00, 3, X_INV,       0};
        tbl[8] = '{0, 0, 16'h0000, '0,    '0,          1,   0,  '0,    1, 16'h1234, 2, X_INV,       0};

        cyc(1, 0, '0, '0, '0, 0, 0, '0);
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].f, tbl[i].e,
                tbl[i].ordy, tbl[i].clr, tbl[i].te);
            chk("vec_valid", 32'(out_valid), 32'(tbl[i].ev));
            chk("vec_level", 32'(level), 32'(tbl[i].elev));
            chk("vec_status", 32'(status), 32'(tbl[i].est));
            chk("vec_trap", 32'(trap), 32'(tbl[i].etr));
            if (tbl[i].ev) chk("vec_out_s", 32'(out_s), 32'(tbl[i].es));
            $display("[TB] vec %0d: out_valid=%0d out_s=%h level=%0d status=%b trap=%0d",
                     i, out_valid, out_s, level, status, trap);
        end

        // Fill to DEPTH, drop an extra push, pop once, refill across the wrap
        cyc(1, 0, '0, '0, '0, 0, 0, '0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, SW'(16'hA000 + k), F_NRM, '0, 0, 0, '0);
        end
        chk("full_in_ready", 32'(in_ready), 32'(0));
        chk("full_level", 32'(level), 32'(4));
        cyc(0, 1, 16'hBEEF, F_NRM, X_INV, 0, 0, '0);
        chk("drop_level", 32'(level), 32'(4));
        chk("drop_status", 32'(status), 32'(0));
        chk("drop_head", 32'(out_s), 32'(16'hA000));
        cyc(0, 1, 16'hBEEF, F_NRM, '0, 1, 0, '0);
        chk("popfull_level", 32'(level), 32'(3));
        chk("popfull_ready", 32'(in_ready), 32'(1));
        cyc(0, 1, 16'hA004, F_NRM, '0, 0, 0, '0);
        exp_drain[0] = 16'hA001;
        exp_drain[1] = 16'hA002;
        exp_drain[2] = 16'hA003;
        exp_drain[3] = 16'hA004;
        for (int k = 0; k < 4; k++) begin
            chk("drain_order", 32'(out_s), 32'(exp_drain[k]));
            cyc(0, 0, '0, '0, '0, 1, 0, '0);
        end
        chk("drain_empty", 32'(out_valid), 32'(0));
        cyc(0, 0, '0, '0, '0, 1, 0, '0);
        chk("pop_empty_level", 32'(level), 32'(0));
        $display("[TB] seq fill/drop/wrap done");

        // Steady push+pop at level 2 for 10 cycles
        cyc(1, 0, '0, '0, '0, 0, 0, '0);
        cyc(0, 1, 16'hB000, F_NRM, '0, 0, 0, '0);
        cyc(0, 1, 16'hB001, F_NRM, '0, 0, 0, '0);
        for (int k = 0; k < 10; k++) begin
            cyc(0, 1, SW'(16'hB002 + k), F_NRM, '0, 1, 0, '0);
            chk("pp_level", 32'(level), 32'(2));
            chk("pp_head", 32'(out_s), 32'(16'hB001 + k));
        end
        $display("[TB] seq push+pop at level 2 done");

        // Reset with three entries buffered and trap asserted
        cyc(0, 1, 16'hC000, F_NRM, X_INX, 0, 0, X_INX);
        chk("rst_pre_trap", 32'(trap), 32'(1));
        cyc(1, 0, '0, '0, '0, 0, 0, X_INX);
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_status", 32'(status), 32'(0));
        chk("rst_trap", 32'(trap), 32'(0));
        cyc(0, 1, 16'hD00D, F_NRM, '0, 0, 0, '0);
        chk("first_push_after_rst", 32'(level), 32'(1));
        chk("first_push_head", 32'(out_s), 32'(16'hD00D));
        $display("[TB] seq mid-operation reset done");

        // Random traffic with phases biased toward full and toward empty
        for (int i = 0; i < 600; i++) begin
            bit r_b, v_b, o_b, c_b;
            r_b = ($urandom_range(0, 79) == 0);
            v_b = ($urandom_range(0, 3) != 0);
            o_b = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                       : ($urandom_range(0, 3) != 0);
            c_b = ($urandom_range(0, 7) == 0);
            cyc(r_b, v_b, SW'($urandom), NTYPES'($urandom), NEXCEPTIONS'($urandom),
                o_b, c_b, NEXCEPTIONS'($urandom));
        end
        $display("[TB] seq random traffic done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
